// File: rtl/rv32e_core_sequencer_pkg.sv
// Shared encodings for the RV32E sequencer: FSM states, legal opcodes, trap causes
// and the decode-time legality check.
package rv32e_core_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_OPCODE  = 2'b01,
    CAUSE_REGIDX  = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } cause_t;

  // RV32E has only x0..x15, so bit 4 of any used register index is illegal.
  // The opcode check wins over the register-index check.
  function automatic cause_t decode_check(input logic [6:0] opcode,
                                          input logic       rd_hi,
                                          input logic       rs1_hi,
                                          input logic       rs2_hi);
    if (opcode != OP_REG && opcode != OP_IMM)
      return CAUSE_OPCODE;
    if (rd_hi || rs1_hi || (opcode == OP_REG && rs2_hi))
      return CAUSE_REGIDX;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/rv32e_fetch_timer.sv
// Counts fetch cycles without imem_valid; expired flags the last cycle allowed
// before the sequencer must give up on the fetch.
module rv32e_fetch_timer #(
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + 8'd1;
  end

  // Fires in the FETCH_TIMEOUT-th waiting cycle, so a valid in that same cycle still wins.
  assign expired = enable && (count == 8'(FETCH_TIMEOUT - 1));

endmodule

// File: rtl/rv32e_core_sequencer.sv
// Multi-cycle control FSM for the RV32E semi-core: fetch, decode-check, operand latch,
// writeback. Owns pc, instr and instret; parks in a sticky trap state on faults.
module rv32e_core_sequencer
  import rv32e_core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        opnd_load,
  output logic        res_load,
  output logic        rf_we,
  output logic        retire,
  output logic [31:0] instret,
  output logic        busy,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instret_q;
  cause_t      cause_q;
  cause_t      dec_cause;
  logic        timer_clear;
  logic        timer_enable;
  logic        timer_expired;

  assign dec_cause    = decode_check(instr_q[6:0], instr_q[11], instr_q[19], instr_q[24]);
  assign timer_clear  = (state != ST_FETCH);
  assign timer_enable = (state == ST_FETCH) && !imem_valid;

  rv32e_fetch_timer #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_fetch_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      instret_q <= '0;
      cause_q   <= CAUSE_NONE;
    end else begin
      if (state == ST_FETCH && imem_valid)
        instr_q <= imem_rdata;
      if (state == ST_FETCH && timer_expired)
        cause_q <= CAUSE_TIMEOUT;
      if (state == ST_DECODE && dec_cause != CAUSE_NONE)
        cause_q <= dec_cause;
      // pc stays at the faulting address on trap: it only advances on retirement.
      if (state == ST_WB) begin
        pc_q      <= pc_q + 32'd4;
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (!halt) state_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_valid)         state_next = ST_DECODE;
        else if (timer_expired) state_next = ST_TRAP;
      end
      ST_DECODE: state_next = (dec_cause == CAUSE_NONE) ? ST_EXEC : ST_TRAP;
      ST_EXEC:   state_next = ST_WB;
      ST_WB:     state_next = halt ? ST_IDLE : ST_FETCH;
      ST_TRAP:   state_next = ST_TRAP;
      default:   state_next = ST_TRAP;
    endcase
  end

  assign imem_req   = (state == ST_FETCH);
  assign imem_addr  = pc_q;
  assign instr      = instr_q;
  assign pc         = pc_q;
  assign opnd_load  = (state == ST_EXEC);
  assign res_load   = (state == ST_WB);
  assign retire     = (state == ST_WB);
  assign rf_we      = (state == ST_WB) && (instr_q[11:7] != 5'd0);
  assign instret    = instret_q;
  assign busy       = (state == ST_FETCH) || (state == ST_DECODE) ||
                      (state == ST_EXEC)  || (state == ST_WB);
  assign trap       = (state == ST_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_rv32e_core_sequencer.sv
// Scoreboard bench for rv32e_core_sequencer: a memory driver predicts each instruction's
// outcome from the ISA rules, a monitor pops predictions when retire or trap appears.
module tb_rv32e_core_sequencer;

  localparam logic [31:0] RPC       = 32'hFFFF_FFFC;
  localparam int          TO        = 4;
  localparam logic [31:0] W_ADD     = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] W_ADD17   = 32'h002088B3;  // add  x17,x1,x2
  localparam logic [31:0] W_ADDI_X0 = 32'h00100013;  // addi x0,x0,1
  localparam logic [31:0] W_BRANCH  = 32'h00000063;  // opcode 1100011

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        halt = 1'b0;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        imem_req, opnd_load, res_load, rf_we, retire, busy, trap;
  logic [31:0] imem_addr, instr, pc, instret;
  logic [1:0]  trap_cause;

  rv32e_core_sequencer #(.RESET_PC(RPC), .FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .instr(instr), .pc(pc),
    .opnd_load(opnd_load), .res_load(res_load), .rf_we(rf_we), .retire(retire),
    .instret(instret), .busy(busy), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_trap;
    logic [1:0]  cause;
    logic [31:0] pc;
    logic [31:0] cnt;
    bit          we;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    int          delay;
  } fetch_t;

  exp_t   sb[$];
  fetch_t plan[$];
  int     errors = 0;
  int     checks = 0;
  int     rnd_illegal = 0;
  int     rnd_timeout = 0;
  int     rnd_maxdly = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // ISA outcome of one fetched word: 0 retires, 1 bad opcode, 2 bad register index.
  function automatic logic [1:0] ref_cause(input logic [31:0] w);
    logic [6:0] op;
    int rd, rs1, rs2;
    op  = w[6:0];
    rd  = int'(w[11:7]);
    rs1 = int'(w[19:15]);
    rs2 = int'(w[24:20]);
    if (op != 7'b0110011 && op != 7'b0010011) return 2'b01;
    if (rd > 15 || rs1 > 15 || (op == 7'b0110011 && rs2 > 15)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] rand_word(input int ill_pct);
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 99) >= ill_pct) begin
      w[6:0] = ($urandom_range(0, 1) != 0) ? 7'b0110011 : 7'b0010011;
      w[11] = 1'b0;
      w[19] = 1'b0;
      w[24] = 1'b0;
      if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    end else if ($urandom_range(0, 1) != 0) begin
      w[6:0] = 7'b0110011;
    end
    return w;
  endfunction

  // Instruction memory: answers each fetch after a chosen delay and predicts the outcome.
  initial begin : driver
    logic [31:0] mpc, mcnt, cur_w;
    logic [1:0]  c;
    int          cur_d, waited;
    bit          have;
    fetch_t      f;
    imem_valid = 1'b0;
    imem_rdata = '0;
    mpc = RPC; mcnt = 0; have = 0; waited = 0; cur_d = 0; cur_w = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mpc = RPC; mcnt = 0; have = 0; waited = 0;
        imem_valid = 1'b0;
      end else if (imem_req) begin
        if (!have) begin
          if (plan.size() > 0) begin
            f = plan.pop_front();
            cur_w = f.word;
            cur_d = f.delay;
          end else begin
            cur_w = rand_word(rnd_illegal);
            cur_d = ($urandom_range(0, 99) < rnd_timeout) ? TO + 3 : $urandom_range(0, rnd_maxdly);
          end
          have = 1; waited = 0;
          if (cur_d >= TO)
            sb.push_back('{is_trap: 1'b1, cause: 2'b11, pc: mpc, cnt: mcnt, we: 1'b0});
        end
        if (waited == cur_d) begin
          imem_valid = 1'b1;
          imem_rdata = cur_w;
          have = 0;
          c = ref_cause(cur_w);
          if (c != 2'b00) begin
            sb.push_back('{is_trap: 1'b1, cause: c, pc: mpc, cnt: mcnt, we: 1'b0});
          end else begin
            sb.push_back('{is_trap: 1'b0, cause: 2'b00, pc: mpc, cnt: mcnt, we: (cur_w[11:7] != 5'd0)});
            mpc = mpc + 32'd4;
            mcnt = mcnt + 32'd1;
          end
        end else begin
          imem_valid = 1'b0;
          imem_rdata = $urandom;
          waited++;
        end
      end else begin
        imem_valid = ($urandom_range(0, 2) == 0);
        imem_rdata = $urandom;
      end
    end
  end

  initial begin : monitor
    bit   trap_seen;
    exp_t e;
    trap_seen = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sb.delete();
        trap_seen = 0;
      end else begin
        if (imem_req) chk("imem_addr_eq_pc", imem_addr, pc);
        if (retire) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_retire: retire at pc %h, expected no retirement", pc);
          end else begin
            e = sb.pop_front();
            chk("retire_kind", 32'(trap_cause), 32'(e.cause));
            chk("retire_pc", pc, e.pc);
            chk("retire_instret", instret, e.cnt);
            chk("retire_rf_we", 32'(rf_we), 32'(e.we));
            chk("retire_res_load", 32'(res_load), 32'd1);
          end
        end
        if (trap && !trap_seen) begin
          trap_seen = 1;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_trap: cause %b at pc %h, expected no trap", trap_cause, pc);
          end else begin
            e = sb.pop_front();
            chk("trap_kind", 32'(e.is_trap), 32'd1);
            chk("trap_cause", 32'(trap_cause), 32'(e.cause));
            chk("trap_pc", pc, e.pc);
            chk("trap_instret", instret, e.cnt);
          end
        end
        if (trap)
          chk("trap_quiet", 32'({imem_req, opnd_load, res_load, rf_we, retire, busy}), 32'd0);
      end
    end
  end

  task automatic do_reset(input bit check_state);
    @(negedge clk);
    #1 reset_n = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    if (check_state) begin
      chk("rst_pc", pc, RPC);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_trap", 32'({trap, trap_cause}), 32'd0);
      chk("rst_outputs", 32'({imem_req, opnd_load, res_load, rf_we, retire, busy}), 32'd0);
    end
    @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_sig(input int which, input int budget, input string nm);
    int n;
    bit hit;
    n = 0; hit = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = trap;
        1:       hit = opnd_load;
        default: hit = retire;
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: event not seen within %0d cycles", nm, budget);
    end
  endtask

  // Per-cycle {imem_req, opnd_load, res_load, rf_we, retire}, starting at cycle 1 after reset.
  task automatic run_table(input string nm, input logic [4:0] tab[$]);
    foreach (tab[k]) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", nm, k + 1),
          32'({imem_req, opnd_load, res_load, rf_we, retire}), 32'(tab[k]));
    end
  endtask

  initial begin : main
    logic [4:0]  t[$];
    logic [31:0] pc_r;
    int          reqs;

    // Steady run: 4-cycle instruction, pc wraps from FFFF_FFFC to 0.
    rnd_illegal = 0; rnd_timeout = 0; rnd_maxdly = 0;
    plan.push_back('{word: W_ADD, delay: 0});
    do_reset(1);
    t = '{5'b10000, 5'b00000, 5'b01000, 5'b00111, 5'b10000};
    run_table("run", t);
    chk("run_pc_wrap", pc, 32'd0);
    chk("run_instret", instret, 32'd1);
    chk("run_instr", instr, W_ADD);

    // Fetch with valid in the 4th request cycle, which is also the timeout cycle.
    plan.push_back('{word: W_ADD, delay: 3});
    do_reset(0);
    t = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b00000, 5'b01000, 5'b00111, 5'b10000};
    run_table("wait", t);
    chk("wait_trap", 32'(trap), 32'd0);

    // Illegal opcode, then illegal register index; later valid pulses are ignored.
    plan.push_back('{word: W_BRANCH, delay: 0});
    do_reset(0);
    wait_sig(0, 10, "opcode_trap_wait");
    repeat (10) @(negedge clk);
    chk("opcode_cause_sticky", 32'({trap, trap_cause}), 32'b101);
    chk("opcode_pc_frozen", pc, RPC);

    plan.push_back('{word: W_ADD17, delay: 0});
    do_reset(0);
    wait_sig(0, 10, "regidx_trap_wait");
    chk("regidx_cause", 32'(trap_cause), 32'b10);

    // Fetch timeout: exactly TO request cycles then trap.
    plan.push_back('{word: W_ADD, delay: 99});
    do_reset(0);
    reqs = 0;
    for (int i = 0; i < 20 && !trap; i++) begin
      @(negedge clk);
      if (imem_req) reqs++;
    end
    chk("timeout_req_cycles", 32'(reqs), 32'(TO));
    chk("timeout_cause", 32'({trap, trap_cause}), 32'b111);

    // Write to x0: retires without rf_we.
    plan.push_back('{word: W_ADDI_X0, delay: 0});
    do_reset(0);
    t = '{5'b10000, 5'b00000, 5'b01000, 5'b00101, 5'b10000};
    run_table("x0", t);
    chk("x0_pc_wrap", pc, 32'd0);

    // Halt during EXEC, resume, then reset in the middle of an instruction.
    do_reset(0);
    wait_sig(1, 20, "halt_exec_wait");
    #1 halt = 1'b1;
    wait_sig(2, 5, "halt_retire_wait");
    pc_r = pc;
    repeat (4) begin
      @(negedge clk);
      chk("halt_idle", 32'({imem_req, busy}), 32'd0);
    end
    chk("halt_pc", pc, pc_r + 32'd4);
    #1 halt = 1'b0;
    @(negedge clk);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, pc_r + 32'd4);
    wait_sig(1, 20, "abort_exec_wait");
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("abort_pc", pc, RPC);
    chk("abort_instret", instret, 32'd0);
    chk("abort_no_retire", 32'({retire, rf_we}), 32'd0);
    #1 reset_n = 1'b1;

    // Randomized episodes: delays, halts, illegal words and timeouts.
    for (int ep = 0; ep < 8; ep++) begin
      rnd_illegal = (ep < 4) ? 0 : 6;
      rnd_timeout = (ep == 7) ? 5 : 0;
      rnd_maxdly  = TO - 1;
      do_reset(0);
      for (int i = 0; i < 250 && !trap; i++) begin
        @(negedge clk);
        #1 halt = ($urandom_range(0, 9) == 0);
      end
      halt = 1'b0;
      if (trap) begin
        repeat (2) @(negedge clk);
        chk("episode_sb_drained", 32'(sb.size()), 32'd0);
      end
    end

    do_reset(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32e_core_sequencer.md
Name: rv32e_core_sequencer

Overview:
- Multi-cycle control FSM for the RV32E semi-core datapath: fetch, decode-check, operand latch, ALU-result writeback.
- Owns the PC and the instruction register.
- Drives the load strobes for the ALU operand and result registers, and the register-file write enable.
- Detects illegal instructions and fetch timeouts, then parks in a sticky trap state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 16, cycles imem_req may stay unanswered before trap; legal range 1..255.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- halt  in  1  request to stop after the current instruction retires.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address; always equals pc.
- imem_valid  in  1  fetch data valid; may arrive in the same cycle as imem_req.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  instruction register; feeds the decoder.
- pc  out  32  current program counter.
- opnd_load  out  1  one-cycle strobe: ALU operand registers capture register-file read data.
- res_load  out  1  one-cycle strobe: result and writeback-data registers capture ALU output.
- rf_we  out  1  register-file write enable, one cycle.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  32  retired-instruction counter.
- busy  out  1  high in FETCH, DECODE, EXEC, WB.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 illegal register index, 11 fetch timeout.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, pc=RESET_PC, instr=0, instret=0, trap=0, trap_cause=00.
  - All strobes, imem_req and busy are 0.
  - An assertion mid-instruction aborts the instruction immediately: no rf_we, no retire.
- States: IDLE, FETCH, DECODE, EXEC, WB, TRAP. All strobes are Moore outputs decoded from state.
- IDLE:
  - halt=0 -> FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - A wait counter clears on entry and increments each cycle without imem_valid.
  - imem_valid=1 -> instr<=imem_rdata, go to DECODE.
  - Counter reaches FETCH_TIMEOUT with no valid -> TRAP, cause 11.
  - imem_valid arriving in the timeout cycle wins: the fetch completes.
- DECODE (1 cycle):
  - Legal opcodes are 7'b0110011 (R-type) and 7'b0010011 (I-type ALU).
  - Any other opcode -> TRAP, cause 01.
  - rd[4]=1, or rs1[4]=1, or (R-type and rs2[4]=1) -> TRAP, cause 10.
  - The opcode check takes priority over the register-index check.
  - Legal -> EXEC.
- EXEC (1 cycle): opnd_load=1 -> WB.
- WB (1 cycle):
  - res_load=1 and retire=1.
  - rf_we=1 only if rd!=0; writes to x0 are suppressed.
  - pc<=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - instret<=instret+1, wrapping modulo 2^32.
  - Next state: halt=1 -> IDLE, else FETCH.
- halt is sampled only in WB and IDLE. It does not cancel an in-flight fetch.
- Minimum latency is 4 cycles per instruction (FETCH with same-cycle valid, DECODE, EXEC, WB). Back-to-back retire pulses are therefore 4 cycles apart.
- TRAP:
  - trap=1; trap_cause held; pc frozen at the faulting instruction's address.
  - No strobes, no imem_req.
  - Exit only via reset_n; halt is ignored.
- imem_rdata is ignored whenever the state is not FETCH.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, TRAP=5;
  - opcode constants OP_REG=7'b0110011 and OP_IMM=7'b0010011;
  - trap_cause codes.
- Sub-module rv32e_fetch_timer holds the fetch wait counter: inputs clear, enable; output expired.

Test Plan:
- Reset to steady run:
  - Stimulus: release reset_n; memory returns add x3,x1,x2 (32'h002081B3) with same-cycle valid, every cycle.
  - Required: opnd_load at cycle 3; res_load, rf_we and retire at cycle 4; pc=4; instret=1; next imem_req at cycle 5.
- Fetch wait states:
  - Stimulus: imem_valid delayed 3 cycles.
  - Required: imem_req held 4 cycles with imem_addr stable; the instruction retires 3 cycles later than in the no-wait case.
- Illegal decode:
  - Opcode 7'b1100011 -> trap=1, cause 01, pc unchanged, no rf_we.
  - Separately, add x17,x1,x2 -> cause 10.
  - Further imem_valid pulses are ignored until reset.
- Timeout:
  - With FETCH_TIMEOUT=4 and imem_valid never asserted -> cause 11 after 4 request cycles.
  - A rerun with valid arriving exactly at cycle 4 retires normally.
- x0 write and wrap:
  - With RESET_PC=32'hFFFF_FFFC, run addi x0,x0,1 -> retire=1 and rf_we=0; pc wraps to 0.
- Halt and mid-run reset:
  - halt=1 during EXEC -> instruction retires, state goes to IDLE with no imem_req.
  - halt=0 -> fetch resumes at the next pc.
  - reset_n pulsed during EXEC -> no retire, pc=RESET_PC, instret=0.
